// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front-end with credit-limited requests, response FIFO and redirect flush
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, drop, count;
  logic [AW-1:0] rptr, wptr;
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic [CW:0] credit;
  logic grant, accept, push, pop;
  assign mem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr = buf_instr[rptr];
  assign instr_pc = buf_pc[rptr];
  // per-cycle handshake qualifiers; requests are capped so buffered plus in-flight never exceeds DEPTH
  always_comb begin
    credit = {1'b0, count} + {1'b0, outstanding};
    mem_req = !rst && !redirect_valid && (credit < (CW+1)'(DEPTH));
    grant = mem_req && mem_gnt;
    accept = mem_rvalid && (outstanding != '0);
    push = accept && (drop == '0);
    pop = instr_valid && instr_ready;
  end
  // PCs, in-flight/drop counters and FIFO pointers; redirect flushes and marks in-flight responses stale
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      rptr <= '0;
      wptr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      resp_pc <= {redirect_pc[31:2], 2'b00};
      outstanding <= outstanding - CW'(accept);
      drop <= outstanding - CW'(accept);
      count <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(accept);
      if (accept && drop != '0) drop <= drop - CW'(1);
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // FIFO storage of {pc, instr} for accepted, non-stale responses
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      buf_pc[wptr] <= resp_pc;
      buf_instr[wptr] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized fetch-stream bench with a pipelined memory model and in-order stream reference
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h00400000;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic mem_req, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_rdata = 0;
  logic redirect_valid = 0, instr_valid, instr_ready = 0;
  logic [31:0] redirect_pc = 0, instr, instr_pc;
  int errors = 0, checks = 0;
  int gnt_pct = 100, rv_pct = 100, lat = 1;
  int unsigned cyc = 0, last_due = 0, mcyc = 0;
  logic [31:0] exp_pc = RPC;
  typedef struct {int unsigned due; logic [31:0] addr;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins; int unsigned t;} pop_t;
  req_t memq[$];
  pop_t pops[$];

  ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h00600413;
    if (a == RPC + 32'd4) return 32'h00400493;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // pipelined instruction memory: in-order responses at least one cycle after grant, killed by rst
  always @(posedge clk) begin
    if (rst) begin
      memq.delete();
      last_due = 0;
    end else begin
      if (mem_rvalid && memq.size() > 0) void'(memq.pop_front());
      if (mem_req && mem_gnt) begin
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        memq.push_back('{last_due, mem_addr});
      end
    end
    cyc++;
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      mem_rvalid = 1;
      mem_rdata = mem_word(memq[0].addr);
    end else begin
      mem_rvalid = 0;
      mem_rdata = $urandom;
    end
    mem_gnt = $urandom_range(99) < gnt_pct;
  end

  // stream reference: after reset or redirect the core must see consecutive PCs with their memory words
  always @(posedge clk) begin
    mcyc++;
    if (rst) exp_pc = RPC;
    else begin
      checks++;
      if (dut.count + dut.outstanding > DEPTH || (mem_req && mem_addr[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL credit: count=%0d outstanding=%0d addr=%h, required count+outstanding<=%0d and aligned addr",
                 dut.count, dut.outstanding, mem_addr, DEPTH);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        pops.push_back('{instr_pc, instr, mcyc});
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int g, input int l);
    gnt_pct = g;
    lat = l;
    rv_pct = 100;
    rst = 1;
    redirect_valid = 0;
    instr_ready = 0;
    step();
    step();
    rst = 0;
    pops.delete();
    #1;
  endtask

  task automatic wait_pops(input int n, input int lim);
    for (int i = 0; i < lim && pops.size() < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: mem_req=%b instr_valid=%b, required 0 0", mem_req, instr_valid);
    end
    rst = 0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h valid=%b, required 1 %h 0", mem_req, mem_addr, instr_valid, RPC);
    end
  endtask

  task automatic test_streaming();
    do_reset(100, 1);
    instr_ready = 1;
    wait_pops(10, 30);
    checks++;
    if (pops.size() < 10) begin
      errors++;
      $display("FAIL stream_count: pops=%0d, required 10", pops.size());
    end else begin
      checks++;
      if (pops[0].pc !== RPC || pops[0].ins !== 32'h00600413 || pops[1].pc !== RPC + 32'd4 || pops[1].ins !== 32'h00400493) begin
        errors++;
        $display("FAIL stream_first: %h/%h %h/%h, required %h/00600413 %h/00400493",
                 pops[0].pc, pops[0].ins, pops[1].pc, pops[1].ins, RPC, RPC + 32'd4);
      end
      for (int k = 1; k < 10; k++) begin
        checks++;
        if (pops[k].t !== pops[0].t + k) begin
          errors++;
          $display("FAIL stream_rate: pop %0d at %0d, required %0d", k, pops[k].t, pops[0].t + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(100, 1);
    repeat (12) step();
    checks++;
    if (dut.count !== 3'd4 || dut.outstanding !== 3'd0 || mem_req !== 1'b0 || pops.size() != 0) begin
      errors++;
      $display("FAIL bp_full: count=%0d out=%0d req=%b pops=%0d, required 4 0 0 0", dut.count, dut.outstanding, mem_req, pops.size());
    end
    instr_ready = 1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC + 32'h10) begin
      errors++;
      $display("FAIL bp_resume: req=%b addr=%h, required 1 %h", mem_req, mem_addr, RPC + 32'h10);
    end
    wait_pops(5, 20);
    checks++;
    if (pops.size() < 5) begin
      errors++;
      $display("FAIL bp_count: pops=%0d, required 5", pops.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (pops[k].pc !== RPC + 32'(4 * k)) begin
          errors++;
          $display("FAIL bp_order: pop %0d pc=%h, required %h", k, pops[k].pc, RPC + 32'(4 * k));
        end
      end
  endtask

  task automatic test_redirect_drops();
    int exp_drop;
    do_reset(100, 3);
    instr_ready = 1;
    for (int i = 0; i < 10 && memq.size() != 2; i++) step();
    checks++;
    if (memq.size() != 2) begin
      errors++;
      $display("FAIL rd_setup: in_flight=%0d, required 2", memq.size());
    end
    exp_drop = memq.size() - (mem_rvalid ? 1 : 0);
    redirect_valid = 1;
    redirect_pc = 32'h00400041;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_noreq: mem_req=%b, required 0", mem_req);
    end
    step();
    redirect_valid = 0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h00400040 || dut.drop !== 3'(exp_drop)) begin
      errors++;
      $display("FAIL rd_target: req=%b addr=%h drop=%0d, required 1 00400040 %0d", mem_req, mem_addr, dut.drop, exp_drop);
    end
    wait_pops(2, 40);
    checks++;
    if (pops.size() < 2 || pops[0].pc !== 32'h00400040 || pops[1].pc !== 32'h00400044) begin
      errors++;
      $display("FAIL rd_stream: pops=%0d first=%h, required >=2 starting 00400040", pops.size(), pops.size() ? pops[0].pc : 32'hx);
    end
  endtask

  task automatic test_simultaneous();
    int exp_n;
    logic [31:0] tgt;
    do_reset(100, 2);
    for (int i = 0; i < 20 && !(dut.count == 2 && mem_rvalid); i++) step();
    checks++;
    if (!(dut.count == 2 && mem_rvalid)) begin
      errors++;
      $display("FAIL sim_setup: count=%0d rvalid=%b, required 2 1", dut.count, mem_rvalid);
    end
    exp_n = memq.size() - 1;
    tgt = $urandom;
    instr_ready = 1;
    redirect_valid = 1;
    redirect_pc = tgt;
    step();
    redirect_valid = 0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || dut.drop !== 3'(exp_n) || dut.outstanding !== 3'(exp_n)) begin
      errors++;
      $display("FAIL sim_flush: valid=%b drop=%0d out=%0d, required 0 %0d %0d", instr_valid, dut.drop, dut.outstanding, exp_n, exp_n);
    end
    wait_pops(3, 40);
    checks++;
    if (pops.size() < 3 || pops[0].pc !== {tgt[31:2], 2'b00}) begin
      errors++;
      $display("FAIL sim_stream: pops=%0d first=%h, required >=3 starting %h", pops.size(), pops.size() ? pops[0].pc : 32'hx, {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_grant_stall();
    do_reset(0, 1);
    instr_ready = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== RPC || dut.fetch_pc !== RPC) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d req=%b addr=%h fetch_pc=%h, required 1 %h %h", i, mem_req, mem_addr, dut.fetch_pc, RPC, RPC);
      end
      step();
    end
    gnt_pct = 100;
    wait_pops(2, 20);
    checks++;
    if (pops.size() < 2 || pops[0].pc !== RPC) begin
      errors++;
      $display("FAIL stall_resume: pops=%0d, required >=2 starting %h", pops.size(), RPC);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(100, 2);
    for (int i = 0; i < 20 && !(dut.count == 3 && memq.size() == 1); i++) step();
    checks++;
    if (!(dut.count == 3 && memq.size() == 1)) begin
      errors++;
      $display("FAIL rst_setup: count=%0d in_flight=%0d, required 3 1", dut.count, memq.size());
    end
    rst = 1;
    step();
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || dut.outstanding !== 3'd0 || dut.count !== 3'd0) begin
      errors++;
      $display("FAIL rst_clear: valid=%b req=%b out=%0d count=%0d, required 0 0 0 0", instr_valid, mem_req, dut.outstanding, dut.count);
    end
    rst = 0;
    pops.delete();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC) begin
      errors++;
      $display("FAIL rst_restart: req=%b addr=%h, required 1 %h", mem_req, mem_addr, RPC);
    end
    instr_ready = 1;
    wait_pops(2, 20);
    checks++;
    if (pops.size() < 2 || pops[0].pc !== RPC) begin
      errors++;
      $display("FAIL rst_stream: pops=%0d, required >=2 starting %h", pops.size(), RPC);
    end
  endtask

  task automatic test_random();
    do_reset(70, 2);
    rv_pct = 80;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = $urandom_range(3) != 0;
      redirect_valid = $urandom_range(24) == 0;
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(49) == 0) lat = $urandom_range(1, 4);
      step();
    end
    redirect_valid = 0;
    instr_ready = 1;
    rv_pct = 100;
    gnt_pct = 100;
    repeat (20) step();
    checks++;
    if (pops.size() < 100) begin
      errors++;
      $display("FAIL random_progress: pops=%0d, required >=100", pops.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_drops();
    test_simultaneous();
    test_grant_stall();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle RV32I core's decode/execute path.
- Owns the fetch PC and issues word requests to a pipelined instruction memory using a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the core through a valid/ready interface.
- Handles redirects from branches and jal: outstanding requests are flushed and their responses discarded.

Parameters:
- RESET_PC, 32'h00400000: fetch PC after reset (start of the text segment).
- DEPTH, 4: FIFO entries; power of 2, minimum 2; also the cap on entries plus in-flight requests.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- mem_req, out, 1: fetch request valid.
- mem_addr, out, 32: word address of the request; bits [1:0] are always 0.
- mem_gnt, in, 1: request accepted this cycle, qualified by mem_req.
- mem_rvalid, in, 1: response valid. Responses return in order, at least 1 cycle after gnt.
- mem_rdata, in, 32: response instruction word.
- redirect_valid, in, 1: flush the stream and restart fetch at redirect_pc.
- redirect_pc, in, 32: new fetch target; bits [1:0] are forced to 0.
- instr_valid, out, 1: FIFO head valid.
- instr, out, 32: head instruction.
- instr_pc, out, 32: PC of the head instruction.
- instr_ready, in, 1: core consumes the head this cycle.

Behaviour:
- State registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next non-dropped response.
  - outstanding: granted requests whose rvalid has not yet arrived, range 0..DEPTH.
  - drop: outstanding responses to discard, drop ≤ outstanding.
  - FIFO: DEPTH entries of {pc, instr}, plus read pointer, write pointer and count.
- Reset (rst=1 at posedge):
  - fetch_pc and resp_pc load RESET_PC.
  - outstanding, drop, count and pointers load 0.
  - mem_req=0 and instr_valid=0 while rst is high.
  - instr and instr_pc are don't-care while instr_valid=0.
  - mem_rvalid is ignored during reset. The memory shares rst and kills its in-flight responses.
- Request issue:
  - mem_req = !rst & !redirect_valid & (count + outstanding < DEPTH).
  - mem_addr = fetch_pc.
  - On mem_req & mem_gnt: fetch_pc += 4 (32-bit wrap) and outstanding increments.
  - mem_req may drop without a grant; there is no stability requirement.
- Response handling (mem_rvalid=1, no redirect):
  - If drop > 0: drop decrements and no push occurs.
  - Otherwise: push {resp_pc, mem_rdata} and resp_pc += 4.
  - In both cases outstanding decrements.
  - rvalid with outstanding=0 is ignored; counters never underflow.
- Output:
  - instr_valid = (count != 0); instr and instr_pc come from the head entry, registered.
  - Pop occurs on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Credit rule:
  - count + outstanding ≤ DEPTH always holds, so the FIFO cannot overflow.
  - The bench asserts this invariant every cycle.
- Redirect (redirect_valid=1 at posedge, priority over everything except rst):
  - fetch_pc and resp_pc load {redirect_pc[31:2], 2'b00}.
  - The FIFO empties: count=0, pointers reset, and any pop that cycle is void.
  - No request is issued that cycle.
  - drop and outstanding both load outstanding − mem_rvalid. A response arriving in the redirect cycle is discarded.
  - A redirect while drop > 0 simply recomputes drop as above. Back-to-back redirects are legal; the last one wins.
- Latency:
  - First mem_req occurs in the cycle after rst deasserts, with addr RESET_PC.
  - A response accepted at edge N gives instr_valid=1 after edge N.
  - A redirect at edge R puts mem_addr=redirect_pc after R.
  - The first redirected instruction can appear no earlier than 2 cycles after R.
- Throughput: 1 instruction/cycle sustained when gnt=1, the response latency is < DEPTH cycles, and instr_ready=1.

Test Plan:
1. Streaming:
   - Stimulus: reset release, gnt=1, 1-cycle latency, memory returns 32'h00600413 at 0x00400000 and 32'h00400493 at 0x00400004, instr_ready=1.
   - Response: instr_pc 0x00400000 then 0x00400004 with those words, then one instruction per cycle with PC +4.
2. Backpressure:
   - Stimulus: instr_ready=0.
   - Response: mem_req falls once count+outstanding=4, and count stays at 4.
   - Stimulus: raise instr_ready.
   - Response: PCs 0x00400000..0x0040000C pop in order, then fetch resumes at 0x00400010.
3. Redirect with drops:
   - Stimulus: latency 3, two requests outstanding, redirect_pc=0x00400041.
   - Response: mem_addr=0x00400040 next cycle, both stale responses dropped, next instr_pc=0x00400040.
4. Simultaneous events:
   - Stimulus: redirect, rvalid and instr_ready all high in one cycle with count=2.
   - Response: instr_valid=0 next cycle, the response is discarded, drop = previous outstanding − 1.
5. Grant stall:
   - Stimulus: mem_gnt=0 for 5 cycles.
   - Response: mem_addr held at 0x00400000 with mem_req=1, and fetch_pc does not advance.
6. Reset mid-stream:
   - Stimulus: rst pulse with 3 FIFO entries and 1 request outstanding.
   - Response: instr_valid=0, outstanding=0, and the first request after release is at 0x00400000.
